// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package riscv_fetch_pkg;

    // Fetch control states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } fetch_state_t;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Size of one instruction in bytes; the PC advances by this amount.
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // All-zero entry, presented on the queue head when nothing is held.
    localparam fetch_entry_t ENTRY_ZERO = '{pc: 32'h0000_0000, instr: 32'h0000_0000};

    // True when an address is not on an instruction boundary.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // Next sequential PC, wrapping modulo 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched instructions. Flush has priority over
// push and pop; a push into a full queue is accepted only when a pop
// frees the head slot on the same edge.
module fetch_queue
    import riscv_fetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  fetch_entry_t              push_entry,
    output fetch_entry_t              head,
    output logic [$clog2(QDEPTH):0]   count
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    fetch_entry_t    mem_q [QDEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   rd_ptr_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            do_pop_s;
    logic            do_push_s;
    logic            wr_en_s;

    // Qualify requests: never pop an empty queue, never overfill.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (flush) begin
            do_pop_s  = 1'b0;
            do_push_s = 1'b0;
        end else begin
            do_pop_s  = pop && (count_q != {CW{1'b0}});
            do_push_s = push && ((count_q < DEPTH_C) || do_pop_s);
        end
    end

    // Next pointer and occupancy values; pointers wrap at QDEPTH (power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_en_s  = 1'b0;
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                wr_en_s  = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written at the tail on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= ENTRY_ZERO;
            end
        end else if (wr_en_s) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Head reads as zero when the queue holds nothing.
    always_comb begin
        if (count_q != {CW{1'b0}}) begin
            head = mem_q[rd_ptr_q];
        end else begin
            head = ENTRY_ZERO;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential fetch front-end: owns the PC, reads the combinational
// instruction memory and queues {pc, instr} pairs for decode. Redirects
// replace the PC and flush the queue; a misaligned redirect parks the unit
// in a terminal fault state until reset.
module instruction_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_en,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_instr,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     if_valid,
    input  logic                     if_ready,
    output logic [31:0]              if_instr,
    output logic [31:0]              if_pc,
    output logic [$clog2(QDEPTH):0]  fq_count,
    output logic                     fetch_fault
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [31:0]     pc_q;
    logic [31:0]     pc_d;
    logic            fault_q;
    logic            fault_d;

    logic            in_fault_s;
    logic            redirect_bad_s;
    logic            redirect_ok_s;
    logic            pop_s;
    logic            push_s;
    logic            flush_s;
    logic [CW-1:0]   q_count_s;
    fetch_entry_t    q_head_s;
    fetch_entry_t    push_entry_s;

    // Classify the current cycle's redirect and handshake events.
    always_comb begin
        in_fault_s     = (state_q == FAULT);
        redirect_bad_s = 1'b0;
        redirect_ok_s  = 1'b0;
        if (!in_fault_s && redirect_valid) begin
            redirect_bad_s = is_misaligned(redirect_pc);
            redirect_ok_s  = !is_misaligned(redirect_pc);
        end else begin
            redirect_bad_s = 1'b0;
            redirect_ok_s  = 1'b0;
        end
        // The head is only offered to decode outside the fault state.
        if_valid = !in_fault_s && (q_count_s != {CW{1'b0}});
        pop_s    = if_valid && if_ready;
        flush_s  = redirect_bad_s || redirect_ok_s;
        // A slot is available if the queue is not full or the head leaves now.
        if ((state_q == RUN) && !redirect_valid) begin
            push_s = (q_count_s < DEPTH_C) || pop_s;
        end else begin
            push_s = 1'b0;
        end
    end

    // Next-state, PC and fault-flag computation in priority order.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (redirect_bad_s) begin
                    state_d = FAULT;
                end else if (fetch_en) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (redirect_bad_s) begin
                    state_d = FAULT;
                end else if (!fetch_en) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                // Unreachable encoding: fail safe into the terminal state.
                state_d = FAULT;
            end
        endcase

        if (in_fault_s || redirect_bad_s) begin
            pc_d = pc_q;
        end else if (redirect_ok_s) begin
            pc_d = redirect_pc;
        end else if (push_s) begin
            pc_d = next_pc(pc_q);
        end else begin
            pc_d = pc_q;
        end

        if (redirect_bad_s) begin
            fault_d = 1'b1;
        end else begin
            fault_d = fault_q;
        end
    end

    // Control state, PC and sticky fault registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    // Pair the current PC with the word the memory returns for it.
    always_comb begin
        push_entry_s.pc    = pc_q;
        push_entry_s.instr = imem_instr;
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .pop        (pop_s),
        .flush      (flush_s),
        .push_entry (push_entry_s),
        .head       (q_head_s),
        .count      (q_count_s)
    );

    assign imem_addr   = pc_q;
    assign if_instr    = q_head_s.instr;
    assign if_pc       = q_head_s.pc;
    assign fq_count    = q_count_s;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus
// randomized traffic compared against a queue-based behavioural model.
module tb_instruction_fetch_unit;

    localparam int QD = 2;
    localparam int CW = $clog2(QD) + 1;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int VW = 1 + 32 + 32 + CW + 32 + 1;

    logic            clk;
    logic            rst_n;
    logic            fetch_en;
    logic [31:0]     imem_addr;
    logic [31:0]     imem_instr;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [31:0]     if_pc;
    logic [CW-1:0]   fq_count;
    logic            fetch_fault;

    int checks;
    int failures;

    // Behavioural model state.
    logic [63:0]     m_q[$];
    logic [31:0]     m_pc;
    bit              m_run;
    bit              m_fault;
    logic [VW-1:0]   exp_vec;
    logic [VW-1:0]   got_vec;

    instruction_fetch_unit #(
        .RESET_PC (RST_PC),
        .QDEPTH   (QD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fq_count       (fq_count),
        .fetch_fault    (fetch_fault)
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_5A5A;
    endfunction

    assign imem_instr = memf(imem_addr);
    assign got_vec = {if_valid, if_pc, if_instr, fq_count, imem_addr, fetch_fault};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rebuild the expected output vector from the model.
    task automatic model_refresh();
        logic        v;
        logic [31:0] p;
        logic [31:0] w;
        v = !m_fault && (m_q.size() > 0);
        p = (m_q.size() > 0) ? m_q[0][63:32] : 32'h0;
        w = (m_q.size() > 0) ? m_q[0][31:0]  : 32'h0;
        exp_vec = {v, p, w, CW'(m_q.size()), m_pc, m_fault};
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc    = RST_PC;
        m_run   = 1'b0;
        m_fault = 1'b0;
        model_refresh();
    endtask

    // Apply one clock edge of the specified behaviour to the model.
    task automatic model_step();
        bit pop;
        if (!m_fault) begin
            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                m_q.delete();
                m_fault = 1'b1;
            end else begin
                pop = (m_q.size() > 0) && if_ready;
                if (redirect_valid) begin
                    m_q.delete();
                    m_pc = redirect_pc;
                end else begin
                    if (pop) void'(m_q.pop_front());
                    if (m_run && (m_q.size() < QD)) begin
                        m_q.push_back({m_pc, memf(m_pc)});
                        m_pc = m_pc + 32'd4;
                    end
                end
                m_run = fetch_en;
            end
        end
        model_refresh();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({if_valid, fq_count, fetch_fault} !== {1'b0, CW'(0), 1'b0} || imem_addr !== RST_PC
            || if_pc !== 32'h0 || if_instr !== 32'h0) begin
            failures++;
            $display("FAIL reset_state got v=%b cnt=%0d flt=%b addr=%h pc=%h ins=%h exp all zero/RESET_PC",
                     if_valid, fq_count, fetch_fault, imem_addr, if_pc, if_instr);
        end
    endtask

    task automatic test_startup();
        do_reset();
        fetch_en = 1'b1;
        if_ready = 1'b1;
        tick();
        checks++;
        if (if_valid !== 1'b0) begin
            failures++;
            $display("FAIL startup_no_valid_yet got=%b exp=0", if_valid);
        end
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== memf(32'h0)) begin
            failures++;
            $display("FAIL startup_first got v=%b pc=%h ins=%h exp v=1 pc=0 ins=%h",
                     if_valid, if_pc, if_instr, memf(32'h0));
        end
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== memf(32'h4)) begin
            failures++;
            $display("FAIL startup_second got v=%b pc=%h ins=%h exp v=1 pc=4 ins=%h",
                     if_valid, if_pc, if_instr, memf(32'h4));
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        do_reset();
        fetch_en = 1'b1;
        if_ready = 1'b0;
        repeat (6) tick();
        checks++;
        if (fq_count !== CW'(2) || imem_addr !== 32'h8 || if_pc !== 32'h0) begin
            failures++;
            $display("FAIL backpressure_full got cnt=%0d addr=%h pc=%h exp cnt=2 addr=8 pc=0",
                     fq_count, imem_addr, if_pc);
        end
        if_ready = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (if_valid !== 1'b1 || if_pc !== exp_pc || if_instr !== memf(exp_pc)) begin
                failures++;
                $display("FAIL drain_seq[%0d] got v=%b pc=%h exp v=1 pc=%h", i, if_valid, if_pc, exp_pc);
            end
            tick();
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_redirect_pop();
        do_reset();
        fetch_en = 1'b1;
        if_ready = 1'b0;
        repeat (4) tick();
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        checks++;
        if (!(if_valid && if_ready) || if_pc !== 32'h0 || fq_count !== CW'(2)) begin
            failures++;
            $display("FAIL redirect_pop_delivered got v=%b pc=%h cnt=%0d exp v=1 pc=0 cnt=2",
                     if_valid, if_pc, fq_count);
        end
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || fq_count !== CW'(0) || imem_addr !== 32'h40) begin
            failures++;
            $display("FAIL redirect_flush got v=%b cnt=%0d addr=%h exp v=0 cnt=0 addr=40",
                     if_valid, fq_count, imem_addr);
        end
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== memf(32'h40)) begin
            failures++;
            $display("FAIL redirect_target got v=%b pc=%h exp v=1 pc=40", if_valid, if_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        fetch_en = 1'b1;
        if_ready = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_top got v=%b pc=%h exp v=1 pc=fffffffc", if_valid, if_pc);
        end
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== memf(32'h0) || fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL wrap_zero got v=%b pc=%h flt=%b exp v=1 pc=0 flt=0", if_valid, if_pc, fetch_fault);
        end
    endtask

    task automatic test_fault();
        do_reset();
        fetch_en = 1'b1;
        if_ready = 1'b0;
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        checks++;
        if (fetch_fault !== 1'b1 || if_valid !== 1'b0 || fq_count !== CW'(0) || imem_addr !== 32'h8) begin
            failures++;
            $display("FAIL fault_entry got flt=%b v=%b cnt=%0d addr=%h exp flt=1 v=0 cnt=0 addr=8",
                     fetch_fault, if_valid, fq_count, imem_addr);
        end
        if_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fetch_en       = i[0];
            redirect_valid = 1'b1;
            redirect_pc    = $urandom() & 32'hFFFF_FFFC;
            tick();
            checks++;
            if (fetch_fault !== 1'b1 || if_valid !== 1'b0 || fq_count !== CW'(0) || imem_addr !== 32'h8) begin
                failures++;
                $display("FAIL fault_sticky[%0d] got flt=%b v=%b cnt=%0d addr=%h exp flt=1 v=0 cnt=0 addr=8",
                         i, fetch_fault, if_valid, fq_count, imem_addr);
            end
        end
        do_reset();
        checks++;
        if (fetch_fault !== 1'b0 || imem_addr !== RST_PC) begin
            failures++;
            $display("FAIL fault_cleared got flt=%b addr=%h exp flt=0 addr=%h", fetch_fault, imem_addr, RST_PC);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        fetch_en = 1'b1;
        if_ready = 1'b0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || imem_addr !== RST_PC || fq_count !== CW'(0)) begin
            failures++;
            $display("FAIL async_reset got v=%b addr=%h cnt=%0d exp v=0 addr=%h cnt=0",
                     if_valid, imem_addr, fq_count, RST_PC);
        end
        do_reset();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            fetch_en       = ($urandom_range(0, 7) != 0);
            if_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom() & 32'h0000_FFFC;
            if (redirect_valid && $urandom_range(0, 9) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
            tick();
            checks++;
            if (got_vec !== exp_vec) begin
                failures++;
                errs++;
                if (errs < 10) $display("FAIL random_cycle[%0d] got=%h exp=%h", i, got_vec, exp_vec);
            end
            if (m_fault && $urandom_range(0, 5) == 0) do_reset();
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect_pop();
        test_wrap();
        test_fault();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
